// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp codes (also decoded by ALU control),
// FSM state encoding, datapath mux selects and the packed control word.
package multicycle_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_BEQ  = 3'b001;
  localparam logic [2:0] ALUOP_BNE  = 3'b010;
  localparam logic [2:0] ALUOP_LUI  = 3'b011;
  localparam logic [2:0] ALUOP_ADDI = 3'b100;
  localparam logic [2:0] ALUOP_ORI  = 3'b101;
  localparam logic [2:0] ALUOP_SW   = 3'b110;
  localparam logic [2:0] ALUOP_R    = 3'b111;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_JR       = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_word_t;

  function automatic logic op_is_legal(input logic [5:0] op, input logic en_jal);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_LUI,
      OP_BEQ, OP_BNE, OP_J: op_is_legal = 1'b1;
      OP_JAL:               op_is_legal = en_jal;
      default:              op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath / ALU control (slave).
interface multicycle_control_fsm_if;
  logic [5:0] Opcode;
  logic       JumpR;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       IllegalOp;

  modport master (
    input  Opcode, JumpR,
    output PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp
  );

  modport slave (
    output Opcode, JumpR,
    input  PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp
  );
endinterface

// File: rtl/multicycle_control_fsm_ctrl_output_decoder.sv
// Moore output decode: state + latched opcode -> datapath control word. Unlisted fields stay 0,
// so unused state encodings produce an all-quiet word.
module ctrl_output_decoder
  import multicycle_control_fsm_pkg::*;
#(
  parameter int ENABLE_JAL = 1
) (
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = !op_is_legal(opcode_i, ENABLE_JAL != 0);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_SW) ? ALUOP_SW : ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = DST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_R;
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = DST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_JR: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_REGA;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (opcode_i)
          OP_ORI:  ctrl_o.alu_op = ALUOP_ORI;
          OP_LUI:  ctrl_o.alu_op = ALUOP_LUI;
          default: ctrl_o.alu_op = ALUOP_ADDI;
        endcase
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = DST_RT;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = opcode_i[0] ? ALUOP_BNE : ALUOP_BEQ;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = opcode_i[0];
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        if (ENABLE_JAL != 0 && opcode_i == OP_JAL) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = DST_RA;
          ctrl_o.mem_to_reg = M2R_PC;
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: state register and next-state sequencing per opcode.
// Outputs come from ctrl_output_decoder. JumpR is consulted only in EXEC_R.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int ENABLE_JAL = 1,
  parameter int STATE_W    = 4
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_control_fsm_if.master bus
);

  state_t     state_q, state_d;
  ctrl_word_t ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:                state_d = S_EXEC_R;
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          OP_JAL:                  state_d = (ENABLE_JAL != 0) ? S_JUMP : S_FETCH;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_EXEC_R:   state_d = bus.JumpR ? S_JR : S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      // Terminal states and unused encodings all return to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  ctrl_output_decoder #(.ENABLE_JAL(ENABLE_JAL)) u_dec (
    .state_i  (state_q),
    .opcode_i (bus.Opcode),
    .ctrl_o   (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNE    = ctrl.branch_ne;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.IllegalOp   = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: two instances, JAL enabled and disabled, driven in lock step.
module tb_multicycle_control_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   excl_viol;

  multicycle_control_fsm_if bus_jal();
  multicycle_control_fsm_if bus_nojal();

  multicycle_control_fsm #(.ENABLE_JAL(1), .STATE_W(4)) u_dut_jal (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_jal)
  );

  multicycle_control_fsm #(.ENABLE_JAL(0), .STATE_W(4)) u_dut_nojal (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nojal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe exclusivity monitored on every cycle of both instances.
  always @(negedge clk) begin
    if (bus_jal.MemWrite && bus_jal.RegWrite)       excl_viol++;
    if (bus_jal.PCWrite && bus_jal.PCWriteCond)     excl_viol++;
    if (bus_nojal.MemWrite && bus_nojal.RegWrite)   excl_viol++;
    if (bus_nojal.PCWrite && bus_nojal.PCWriteCond) excl_viol++;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op);
    bus_jal.Opcode   = op;
    bus_nojal.Opcode = op;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_fetch(input string tag);
    check_eq({tag, "_memread"}, {7'd0, bus_jal.MemRead}, 8'd1);
    check_eq({tag, "_irwrite"}, {7'd0, bus_jal.IRWrite}, 8'd1);
    check_eq({tag, "_pcwrite"}, {7'd0, bus_jal.PCWrite}, 8'd1);
    check_eq({tag, "_aluop"},   {5'd0, bus_jal.ALUOp},   8'd0);
    check_eq({tag, "_srcb"},    {6'd0, bus_jal.ALUSrcB}, 8'd1);
  endtask

  logic rw_seen;

  initial begin
    checks    = 0;
    failures  = 0;
    excl_viol = 0;
    reset     = 1'b1;
    bus_jal.JumpR   = 1'b0;
    bus_nojal.JumpR = 1'b0;
    set_op(6'b000000);
    #2;
    check_fetch("rst");
    check_eq("rst_nojal_memread", {7'd0, bus_nojal.MemRead}, 8'd1);
    check_eq("rst_memwrite", {7'd0, bus_jal.MemWrite}, 8'd0);
    check_eq("rst_regwrite", {7'd0, bus_jal.RegWrite}, 8'd0);
    do_reset();

    // LW: five cycles
    set_op(6'b100011);
    check_fetch("lw_fetch");
    step();
    check_eq("lw_dec_srcb", {6'd0, bus_jal.ALUSrcB}, 8'd3);
    check_eq("lw_dec_ill",  {7'd0, bus_jal.IllegalOp}, 8'd0);
    step();
    check_eq("lw_addr_aluop", {5'd0, bus_jal.ALUOp}, 8'd0);
    check_eq("lw_addr_srca",  {7'd0, bus_jal.ALUSrcA}, 8'd1);
    check_eq("lw_addr_srcb",  {6'd0, bus_jal.ALUSrcB}, 8'd2);
    step();
    check_eq("lw_rd_iord",    {7'd0, bus_jal.IorD}, 8'd1);
    check_eq("lw_rd_memread", {7'd0, bus_jal.MemRead}, 8'd1);
    check_eq("lw_rd_irwrite", {7'd0, bus_jal.IRWrite}, 8'd0);
    step();
    check_eq("lw_wb_m2r",   {6'd0, bus_jal.MemtoReg}, 8'd1);
    check_eq("lw_wb_rw",    {7'd0, bus_jal.RegWrite}, 8'd1);
    check_eq("lw_wb_dst",   {6'd0, bus_jal.RegDst}, 8'd0);
    step();
    check_fetch("lw_end");

    // SW with reset landing in MEM_WR
    set_op(6'b101011);
    step();
    step();
    check_eq("sw_addr_aluop", {5'd0, bus_jal.ALUOp}, 8'd6);
    step();
    check_eq("sw_wr_memwrite", {7'd0, bus_jal.MemWrite}, 8'd1);
    check_eq("sw_wr_iord",     {7'd0, bus_jal.IorD}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("sw_rst_memwrite", {7'd0, bus_jal.MemWrite}, 8'd0);
    check_eq("sw_rst_regwrite", {7'd0, bus_jal.RegWrite}, 8'd0);
    check_fetch("sw_rst_async");
    step();
    check_fetch("sw_rst_held");
    reset = 1'b0;
    step();
    check_eq("post_rst_decode_srcb", {6'd0, bus_jal.ALUSrcB}, 8'd3);

    // R-type without and with JR
    do_reset();
    set_op(6'b000000);
    step();
    step();
    check_eq("r_exec_aluop", {5'd0, bus_jal.ALUOp}, 8'd7);
    check_eq("r_exec_srcb",  {6'd0, bus_jal.ALUSrcB}, 8'd0);
    step();
    check_eq("r_wb_dst", {6'd0, bus_jal.RegDst}, 8'd1);
    check_eq("r_wb_rw",  {7'd0, bus_jal.RegWrite}, 8'd1);
    step();
    check_fetch("r_end");
    bus_jal.JumpR   = 1'b1;
    bus_nojal.JumpR = 1'b1;
    rw_seen = 1'b0;
    step();
    rw_seen |= bus_jal.RegWrite;
    step();
    rw_seen |= bus_jal.RegWrite;
    check_eq("jr_exec_aluop", {5'd0, bus_jal.ALUOp}, 8'd7);
    step();
    rw_seen |= bus_jal.RegWrite;
    check_eq("jr_pcsrc",   {6'd0, bus_jal.PCSource}, 8'd3);
    check_eq("jr_pcwrite", {7'd0, bus_jal.PCWrite}, 8'd1);
    step();
    check_eq("jr_no_regwrite", {7'd0, rw_seen}, 8'd0);
    check_fetch("jr_end");
    bus_jal.JumpR   = 1'b0;
    bus_nojal.JumpR = 1'b0;

    // BNE then BEQ: three cycles each
    set_op(6'b000101);
    step();
    step();
    check_eq("bne_aluop", {5'd0, bus_jal.ALUOp}, 8'd2);
    check_eq("bne_pwc",   {7'd0, bus_jal.PCWriteCond}, 8'd1);
    check_eq("bne_bne",   {7'd0, bus_jal.BranchNE}, 8'd1);
    check_eq("bne_pcsrc", {6'd0, bus_jal.PCSource}, 8'd1);
    check_eq("bne_pcw",   {7'd0, bus_jal.PCWrite}, 8'd0);
    step();
    check_fetch("bne_end");
    set_op(6'b000100);
    step();
    step();
    check_eq("beq_aluop", {5'd0, bus_jal.ALUOp}, 8'd1);
    check_eq("beq_bne",   {7'd0, bus_jal.BranchNE}, 8'd0);
    step();
    check_fetch("beq_end");

    // ORI / LUI through EXEC_I and I_WB
    set_op(6'b001101);
    step();
    step();
    check_eq("ori_aluop", {5'd0, bus_jal.ALUOp}, 8'd5);
    step();
    check_eq("ori_wb_rw",  {7'd0, bus_jal.RegWrite}, 8'd1);
    check_eq("ori_wb_dst", {6'd0, bus_jal.RegDst}, 8'd0);
    step();
    set_op(6'b001111);
    step();
    step();
    check_eq("lui_aluop", {5'd0, bus_jal.ALUOp}, 8'd3);
    step();
    step();
    check_fetch("lui_end");

    // JAL on both instances
    do_reset();
    set_op(6'b000011);
    step();
    check_eq("jal_dec_ill",       {7'd0, bus_jal.IllegalOp}, 8'd0);
    check_eq("nojal_dec_ill",     {7'd0, bus_nojal.IllegalOp}, 8'd1);
    step();
    check_eq("jal_dst",   {6'd0, bus_jal.RegDst}, 8'd2);
    check_eq("jal_m2r",   {6'd0, bus_jal.MemtoReg}, 8'd2);
    check_eq("jal_rw",    {7'd0, bus_jal.RegWrite}, 8'd1);
    check_eq("jal_pcsrc", {6'd0, bus_jal.PCSource}, 8'd2);
    check_eq("nojal_back_fetch", {7'd0, bus_nojal.IRWrite}, 8'd1);
    check_eq("nojal_no_rw",      {7'd0, bus_nojal.RegWrite}, 8'd0);
    step();
    check_fetch("jal_end");

    // Plain J: no register write
    do_reset();
    set_op(6'b000010);
    step();
    step();
    check_eq("j_pcsrc", {6'd0, bus_jal.PCSource}, 8'd2);
    check_eq("j_rw",    {7'd0, bus_jal.RegWrite}, 8'd0);
    step();

    // Unsupported opcode: single-cycle IllegalOp
    set_op(6'b111111);
    check_eq("ill_fetch", {7'd0, bus_jal.IllegalOp}, 8'd0);
    step();
    check_eq("ill_dec",      {7'd0, bus_jal.IllegalOp}, 8'd1);
    check_eq("ill_memwrite", {7'd0, bus_jal.MemWrite}, 8'd0);
    check_eq("ill_regwrite", {7'd0, bus_jal.RegWrite}, 8'd0);
    step();
    check_eq("ill_cleared", {7'd0, bus_jal.IllegalOp}, 8'd0);
    check_fetch("ill_end");

    step();
    check_eq("exclusivity", excl_viol[7:0], 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
